// File: rtl/seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_alu                                                       |
// | Purpose  : Multi-cycle sequential ALU. Single-cycle arithmetic, logic    |
// |            and branch-compare ops; bit-serial SHL/SHR; optional          |
// |            shift-add multiplier. Results are registered and validated    |
// |            by a one-cycle done pulse.                                    |
// | Options  : SEQ_ALU_MUL_EN - when defined, op 13 is an unsigned MUL.      |
// |            When undefined, op 13 is illegal and no multiplier state or   |
// |            datapath is built.                                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic             zero,
  output logic             err
);

  // Counter is one bit wider than shamt so it can also hold WIDTH for MUL.
  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORR = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_TCP = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_LHI = 4'd8;
  localparam logic [3:0] OP_BNE = 4'd9;
  localparam logic [3:0] OP_BEQ = 4'd10;
  localparam logic [3:0] OP_BGZ = 4'd11;
  localparam logic [3:0] OP_BLZ = 4'd12;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd13;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
`ifdef SEQ_ALU_MUL_EN
    , ST_MUL = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // shift register / product accumulator
  logic [CW-1:0]    cnt_q, cnt_d;   // remaining iterations
  logic             shr_q, shr_d;   // latched shift direction

  logic [WIDTH-1:0] imm_c;
  logic             imm_zero;
  logic             imm_err;
  logic [WIDTH-1:0] shift_nxt;

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_nxt;
`endif

  // Single-cycle result computed straight from the inputs sampled with start.
  always_comb begin
    imm_c    = c_q;
    imm_zero = 1'b0;
    imm_err  = 1'b0;
    case (op)
      OP_ADD:  imm_c = A + B;
      OP_SUB:  imm_c = A - B;
      OP_AND:  imm_c = A & B;
      OP_ORR:  imm_c = A | B;
      OP_NOT:  imm_c = ~A;
      OP_TCP:  imm_c = -A;
      OP_SHL:  imm_c = A;              // only reached here with shamt == 0
      OP_SHR:  imm_c = A;
      OP_LHI:  imm_c = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_BNE:  imm_zero = (A != B);    // branch compares keep C
      OP_BEQ:  imm_zero = (A == B);
      OP_BGZ:  imm_zero = ~A[WIDTH-1] & (|A);
      OP_BLZ:  imm_zero = A[WIDTH-1];
`ifdef SEQ_ALU_MUL_EN
      OP_MUL:  imm_c = c_q;            // multi-cycle, never committed from here
`endif
      default: begin
        imm_c   = '0;
        imm_err = 1'b1;
      end
    endcase
  end

  // One-bit step of the serial shifter and (optionally) the shift-add multiplier.
  always_comb begin
    shift_nxt = shr_q ? {acc_q[WIDTH-1], acc_q[WIDTH-1:1]} : {acc_q[WIDTH-2:0], 1'b0};
`ifdef SEQ_ALU_MUL_EN
    prod_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    c_d     = c_q;
    zero_d  = zero_q;
    err_d   = err_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    shr_d   = shr_q;
`ifdef SEQ_ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (((op == OP_SHL) || (op == OP_SHR)) && (shamt != '0)) begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
            acc_d   = A;
            cnt_d   = {1'b0, shamt};
            shr_d   = (op == OP_SHR);
`ifdef SEQ_ALU_MUL_EN
          end else if (op == OP_MUL) begin
            state_d  = ST_MUL;
            busy_d   = 1'b1;
            acc_d    = '0;
            mcand_d  = A;
            mplier_d = B;
            cnt_d    = CW'(WIDTH);
`endif
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            c_d     = imm_c;
            zero_d  = imm_zero;
            err_d   = imm_err;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = shift_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          c_d     = shift_nxt;
          zero_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      ST_MUL: begin
        acc_d    = prod_nxt;
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          c_d     = prod_nxt;
          zero_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;             // start is ignored during the done cycle
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      c_q      <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      shr_q    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      c_q      <= c_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      shr_q    <= shr_d;
`ifdef SEQ_ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign C    = c_q;
  assign zero = zero_q;
  assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_alu                                                    |
// | Purpose  : Self-checking bench for seq_alu (WIDTH=16) with a behavioural |
// |            reference model; follows SEQ_ALU_MUL_EN for op 13.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seq_alu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  shamt;
  logic        busy;
  logic        done;
  logic [15:0] C;
  logic        zero;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_c  = '0;   // C the model believes the DUT currently holds

  seq_alu #(.WIDTH(16), .SHW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .C     (C),
    .zero  (zero),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour: result, flags and latency of one operation.
  task automatic model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] s, inout logic [15:0] ec, output logic ez,
                       output logic ee, output int lat);
    logic signed [15:0] sa;
    logic [31:0]        prod;
    sa  = a;
    ez  = 1'b0;
    ee  = 1'b0;
    lat = 1;
    case (o)
      4'd0:  ec = a + b;
      4'd1:  ec = a - b;
      4'd2:  ec = a & b;
      4'd3:  ec = a | b;
      4'd4:  ec = ~a;
      4'd5:  ec = 16'd0 - a;
      4'd6:  begin ec = a << s;  lat = int'(s) + 1; end
      4'd7:  begin ec = sa >>> s; lat = int'(s) + 1; end
      4'd8:  ec = b * 16'd256;
      4'd9:  ez = (a != b);
      4'd10: ez = (a == b);
      4'd11: ez = (sa > 16'sd0);
      4'd12: ez = (sa < 16'sd0);
`ifdef SEQ_ALU_MUL_EN
      4'd13: begin prod = a * b; ec = prod[15:0]; lat = 17; end
`endif
      default: begin ec = 16'd0; ee = 1'b1; end
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if ({busy, done, C, zero, err} !== 20'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b C=%h zero=%b err=%b, required all zero",
               busy, done, C, zero, err);
    end
    exp_c = 16'd0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Issue one op from IDLE, scramble the inputs after acceptance and check
  // latency, busy, output stability before done, the result, and done width.
  task automatic run_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] s, input string name);
    logic [15:0] ec;
    logic        ez, ee;
    int          lat, n;
    logic [17:0] held;
    bit          early, busy_bad;
    ec = exp_c;
    model(o, a, b, s, ec, ez, ee, lat);
    held     = {C, zero, err};
    early    = 1'b0;
    busy_bad = 1'b0;
    op = o; A = a; B = b; shamt = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 4'($urandom); A = 16'($urandom); B = 16'($urandom); shamt = 4'($urandom);
    n = 1;
    while (!done && n < 100) begin
      if ({C, zero, err} !== held) early = 1'b1;
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done !== 1'b1 || n !== lat) begin
      errors++;
      $display("FAIL %s latency: done=%b after %0d cycles, required done after %0d", name, done, n, lat);
    end
    checks++;
    if ({C, zero, err} !== {ec, ez, ee}) begin
      errors++;
      $display("FAIL %s result: C=%h zero=%b err=%b, required C=%h zero=%b err=%b",
               name, C, zero, err, ec, ez, ee);
    end
    checks++;
    if (early || busy_bad || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_hold: early_change=%b busy_bad=%b busy_at_done=%b, required 0 0 0",
               name, early, busy_bad, busy);
    end
    exp_c = ec;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b one cycle later, required 0", name, done);
    end
  endtask

  task automatic test_vectors();
    run_op(4'd0,  16'h7FFF, 16'h0001, 4'd0, "add_ovf");
    run_op(4'd7,  16'h8004, 16'h1111, 4'd3, "shr3");
    run_op(4'd7,  16'h8004, 16'h2222, 4'd0, "shr0");
    run_op(4'd6,  16'h0001, 16'h0000, 4'd15, "shl15");
    run_op(4'd13, 16'h0123, 16'h0010, 4'd0, "mul_op13");
    run_op(4'd11, 16'h0000, 16'h0000, 4'd0, "bgz_0");
    run_op(4'd11, 16'h0001, 16'h0000, 4'd0, "bgz_1");
    run_op(4'd12, 16'hFFFF, 16'h0000, 4'd0, "blz_neg");
    run_op(4'd8,  16'h1234, 16'h00AB, 4'd0, "lhi");
    run_op(4'd15, 16'h1234, 16'h5678, 4'd0, "illegal15");
    run_op(4'd5,  16'h0001, 16'h0000, 4'd0, "tcp");
    run_op(4'd14, 16'h0001, 16'h0002, 4'd0, "illegal14");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
             4'($urandom), $sformatf("rand%0d", i));
    end
  endtask

  // A start pulsed while a long op runs must be ignored entirely.
  task automatic test_ignore_start();
    logic [3:0]  lo, ls;
    logic [15:0] la, lb, ec;
    logic        ez, ee;
    int          lat, ndone;
`ifdef SEQ_ALU_MUL_EN
    lo = 4'd13; la = 16'h00FF; lb = 16'h0101; ls = 4'd0;
`else
    lo = 4'd6;  la = 16'h0003; lb = 16'h0000; ls = 4'd14;
`endif
    ec = exp_c;
    model(lo, la, lb, ls, ec, ez, ee, lat);
    op = lo; A = la; B = lb; shamt = ls; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    op = 4'd0; A = 16'h0001; B = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < lat + 6; i++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    checks++;
    if (ndone !== 1 || {C, zero, err} !== {ec, ez, ee}) begin
      errors++;
      $display("FAIL ignore_start: dones=%0d C=%h zero=%b err=%b, required 1 done C=%h zero=%b err=%b",
               ndone, C, zero, err, ec, ez, ee);
    end
    exp_c = ec;
  endtask

  // Start raised during the done cycle is ignored there and taken in IDLE.
  task automatic test_back_to_back();
    run_op(4'd0, 16'h0010, 16'h0020, 4'd0, "b2b_add1");
    run_op(4'd1, 16'h0010, 16'h0020, 4'd0, "b2b_sub2");
    op = 4'd6; A = 16'h0005; shamt = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(posedge clk); #1;
    end
    op = 4'd0; A = 16'h1000; B = 16'h0234; start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: done=%b on the cycle after done, required 0", done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || C !== 16'h1234 || err !== 1'b0) begin
      errors++;
      $display("FAIL start_after_done: done=%b C=%h err=%b, required done=1 C=1234 err=0", done, C, err);
    end
    exp_c = 16'h1234;
    @(posedge clk); #1;
  endtask

  // Reset in the middle of a long op aborts it with no trailing done.
  task automatic test_reset_mid();
    int ndone;
    bit busy_seen;
    op = 4'd13; A = 16'h0101; B = 16'h0303; shamt = 4'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 4'd6; A = 16'h0001; shamt = 4'd12; start = 1'b1;   // either way a long op is running
    repeat (3) @(posedge clk);
    #2;
    start = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, C, zero, err} !== 20'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b C=%h zero=%b err=%b, required all zero",
               busy, done, C, zero, err);
    end
    exp_c = 16'd0;
    @(posedge clk); #3;
    reset = 1'b0;
    ndone = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (busy) busy_seen = 1'b1;
    end
    checks++;
    if (ndone !== 0 || busy_seen) begin
      errors++;
      $display("FAIL reset_abort: dones=%0d busy_seen=%b after reset, required 0 and 0", ndone, busy_seen);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(4'd0, 16'hFFFF, 16'h0002, 4'd0, "first_after_reset");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; A = '0; B = '0; shamt = '0;
    test_reset();
    test_vectors();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
